vga_timing_receiver: RTL

- Sink-side counterpart of the VGA timing generator: samples an incoming HSync/VSync/3-bit colour stream and recovers the line length and frame height.
- Locks onto the stream once it is consistent, then emits active-pixel coordinates with the matching colour sample.
- Used as a capture/loopback checker for the display path and as a front end for frame-grab logic.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_sync_edge.sv | 25 ++
 rtl/vga_timing_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions used by both the generator and the receiver.
package vga_pkg;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam int H_PULSE      = 96;
  localparam int H_BACK       = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT      = 16;
  localparam int H_TOTAL      = H_PULSE + H_BACK + H_ACTIVE_DEF + H_FRONT;
  localparam int V_PULSE      = 2;
  localparam int V_BACK       = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT      = 10;
  localparam int V_TOTAL      = V_PULSE + V_BACK + V_ACTIVE_DEF + V_FRONT;

  localparam int H_START_DEF     = H_PULSE + H_BACK;
  localparam int V_START_DEF     = V_PULSE + V_BACK;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int TIMEOUT_DEF     = 4095;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchroniser for one sync line plus a pixel-rate falling-edge detector.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic din,
  output logic fall
);
  logic s1, s2, last;

  // The edge flop only advances on pixel samples so a slow pixel strobe sees each level once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      last <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (pix_en) last <= s2;
    end
  end

  assign fall = pix_en && last && !s2;
endmodule

// File: rtl/vga_timing_receiver.sv
// VGA sink: measures line/frame geometry, locks on a stable stream, emits active-pixel coordinates.
module vga_timing_receiver
  import vga_pkg::*;
#(
  parameter int H_START     = H_START_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_START     = V_START_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iPixEn,
  input  logic        iHSync,
  input  logic        iVSync,
  input  logic [2:0]  iColor,
  output logic        oLocked,
  output logic        oPixValid,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [2:0]  oColor,
  output logic        oFrameStart,
  output logic [11:0] oLineLen,
  output logic [11:0] oFrameLines,
  output logic        oErr
);
  localparam logic [11:0] HS = 12'(H_START);
  localparam logic [11:0] HE = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] VS = 12'(V_START);
  localparam logic [11:0] VE = 12'(V_START + V_ACTIVE);
  localparam logic [11:0] TO = 12'(TIMEOUT);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

  logic        hfall, vfall;
  logic [2:0]  col_s1, col_s2;
  logic [11:0] h_cnt, v_cnt, ref_len, ref_lines;
  logic [11:0] h_nxt, v_nxt, meas_len, meas_lines;
  logic [9:0]  x_nxt, y_nxt;
  logic [3:0]  fc;
  logic        h_bad, v_bad, loss, pix_ok;
  state_t      state;

  vga_sync_edge u_hs (.clk(clk), .rst(rst), .pix_en(iPixEn), .din(iHSync), .fall(hfall));
  vga_sync_edge u_vs (.clk(clk), .rst(rst), .pix_en(iPixEn), .din(iVSync), .fall(vfall));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= iColor;
      col_s2 <= col_s1;
    end
  end

  // Frame height counts the line whose HSync edge coincides with the VSync edge.
  always_comb begin
    h_nxt      = hfall ? 12'd0 : sat_inc(h_cnt);
    v_nxt      = vfall ? 12'd0 : (hfall ? v_cnt + 12'd1 : v_cnt);
    meas_len   = h_cnt + 12'd1;
    meas_lines = v_cnt + {11'd0, hfall};
    x_nxt      = 10'(h_nxt - HS);
    y_nxt      = 10'(v_nxt - VS);
    h_bad      = hfall && (meas_len != ref_len);
    v_bad      = vfall && (meas_lines != ref_lines);
    loss       = (state == LOCKED) && (h_bad || v_bad || h_cnt == TO);
    pix_ok     = (state == LOCKED) && (h_nxt >= HS) && (h_nxt < HE) &&
                 (v_nxt >= VS) && (v_nxt < VE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      h_cnt       <= '0;
      v_cnt       <= '0;
      ref_len     <= '0;
      ref_lines   <= '0;
      fc          <= '0;
      oLocked     <= 1'b0;
      oPixValid   <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oColor      <= '0;
      oFrameStart <= 1'b0;
      oLineLen    <= '0;
      oFrameLines <= '0;
      oErr        <= 1'b0;
    end else begin
      oErr        <= 1'b0;
      oFrameStart <= 1'b0;
      oPixValid   <= iPixEn && pix_ok;
      if (iPixEn) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        if (hfall) oLineLen <= meas_len;
        if (vfall) oFrameLines <= meas_lines;
        if (pix_ok) begin
          oX     <= x_nxt;
          oY     <= y_nxt;
          oColor <= col_s2;
        end
      end
      case (state)
        SEARCH: if (vfall) begin
          state   <= ACQUIRE;
          fc      <= '0;
          ref_len <= '0;
        end
        ACQUIRE: begin
          if (hfall && ref_len != '0 && meas_len != ref_len) begin
            state <= SEARCH;
          end else begin
            if (hfall && ref_len == '0) ref_len <= meas_len;
            if (vfall) begin
              if (fc != '0 && meas_lines != ref_lines) begin
                fc <= '0;
              end else begin
                fc        <= fc + 4'd1;
                ref_lines <= meas_lines;
                if (fc + 4'd1 == LF) begin
                  state       <= LOCKED;
                  oLocked     <= 1'b1;
                  oFrameStart <= 1'b1;
                end
              end
            end
          end
        end
        LOCKED: begin
          if (loss) begin
            oErr    <= 1'b1;
            oLocked <= 1'b0;
            state   <= SEARCH;
          end else if (vfall) begin
            oFrameStart <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule
